banked_mem_responder: RTL

- Four-bank interleaved main-memory responder serving the cache controller's memory port; cache issues Rd/Wr with Addr/DataIn, responder returns DataOut.
- Implements the bank-interleave, bank-busy and fixed read-latency timing that the controller's 4-cycle burst write-back/refill sequence depends on.
- Sits between the cache controller and the system boundary; one request per cycle max.

---
 rtl/banked_mem_responder_if.sv | 25 ++
 rtl/banked_mem_responder.sv | 112 +++++++++++
 2 files changed

// File: rtl/banked_mem_responder_if.sv
// Cache-controller memory port: request side driven by the cache (master),
// response side driven by the banked memory responder (slave).
interface banked_mem_responder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] Addr;
  logic [15:0]       DataIn;
  logic              Rd;
  logic              Wr;
  logic [15:0]       DataOut;
  logic              DataValid;
  logic              Stall;
  logic [3:0]        Busy;
  logic              err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, DataValid, Stall, Busy, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, DataValid, Stall, Busy, err
  );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved memory responder with per-bank occupancy counters and
// a fixed two-cycle read latency. Bank = Addr[2:1], row = Addr[ADDR_W-1:3].
// Optional macro MEM_ERR_CHECK_EN: flags and drops Rd&Wr or odd addresses;
// without it err is 0, Rd&Wr acts as a write and Addr[0] is ignored.
module banked_mem_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BANK_CYC   = 4,
  parameter int unsigned BANK_DEPTH = 2 ** (ADDR_W - 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  banked_mem_responder_if.slave bus
);

  localparam int unsigned CntW = $clog2(BANK_CYC);
  localparam int unsigned RowW = ADDR_W - 3;
  localparam int unsigned IdxW = RowW + 2;

  logic            req;
  logic            illegal;
  logic            rd_eff;
  logic            wr_eff;
  logic            accept;
  logic [1:0]      bank;
  logic [RowW-1:0] row;
  logic [IdxW-1:0] idx;
  logic [3:0]      busy;

  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  logic [15:0]     mem_q [4*BANK_DEPTH];

  logic            rd_v1_q;
  logic [IdxW-1:0] idx1_q;
  logic [15:0]     dout_q;
  logic            dv_q;

  assign req  = bus.Rd | bus.Wr;
  assign bank = bus.Addr[2:1];
  assign row  = bus.Addr[ADDR_W-1:3];
  assign idx  = {bank, row};

`ifdef MEM_ERR_CHECK_EN
  assign illegal = (bus.Rd & bus.Wr) | bus.Addr[0];
  assign rd_eff  = bus.Rd;
  assign wr_eff  = bus.Wr;
  assign bus.err = req & illegal;
`else
  // Write wins over a simultaneous read; the byte-offset bit is dropped.
  logic unused_addr0;
  assign unused_addr0 = bus.Addr[0];
  assign illegal      = 1'b0;
  assign rd_eff       = bus.Rd & ~bus.Wr;
  assign wr_eff       = bus.Wr;
  assign bus.err      = 1'b0;
`endif

  assign bus.Stall = req & ~illegal & busy[bank];
  assign accept    = req & ~illegal & ~busy[bank];
  assign bus.Busy  = busy;

  // Per-bank occupancy: reload on accept, otherwise count down to zero.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      busy[b]  = (cnt_q[b] != '0);
      cnt_d[b] = cnt_q[b];
      if (accept && (bank == 2'(b))) begin
        cnt_d[b] = CntW'(BANK_CYC - 1);
      end else if (cnt_q[b] != '0) begin
        cnt_d[b] = cnt_q[b] - 1'b1;
      end
    end
  end

  // Counter state; cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  // Storage array; not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (accept && wr_eff) begin
      mem_q[idx] <= bus.DataIn;
    end
  end

  // Two-stage read pipeline: latch index, then register the word (zero when idle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1_q <= 1'b0;
      idx1_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      rd_v1_q <= accept & rd_eff;
      if (accept && rd_eff) begin
        idx1_q <= idx;
      end
      dout_q <= rd_v1_q ? mem_q[idx1_q] : 16'h0000;
      dv_q   <= rd_v1_q;
    end
  end

  assign bus.DataOut   = dout_q;
  assign bus.DataValid = dv_q;

endmodule
